// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with N combinational read ports, one
// synchronous write port, write-to-read bypass, hardwired-zero x0, and a
// pending-write scoreboard with a running count of pending registers.
module regfile_sb #(
    parameter  int DATA_W   = 64,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pending_cnt
);

    // Storage exists only for x1..x(NUM_REGS-1); x0 reads as zero.
    logic [DATA_W-1:0] mem [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] pending_reg;
    logic [NUM_REGS-1:1] pending_next;
    logic [ADDR_W:0]     cnt_next;

    logic wr_valid;
    logic set_valid;
    logic clr_valid;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_valid  = we && (wr_addr != '0);
    assign set_valid = issue_valid && (issue_addr != '0);
    // A same-cycle issue to the written register keeps it pending: the new
    // producer supersedes the one that is retiring now.
    assign clr_valid = wr_valid && !(set_valid && (issue_addr == wr_addr));

    // Data storage: commit the write port, discarding writes to x0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Per-register next pending state: flush beats issue, issue beats write.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_valid && (issue_addr == ADDR_W'(gi));
            assign clr_hit = clr_valid && (wr_addr == ADDR_W'(gi));
            assign pending_next[gi] = flush   ? 1'b0 :
                                      set_hit ? 1'b1 :
                                      clr_hit ? 1'b0 : pending_reg[gi];
        end
    endgenerate

    // Incremental popcount: at most one bit rises and one bit falls per cycle.
    always_comb begin
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        cnt_next = pending_cnt;
        if (set_valid) begin
            cnt_inc = !pending_reg[issue_addr];
        end
        if (clr_valid) begin
            cnt_dec = pending_reg[wr_addr];
        end
        if (flush) begin
            cnt_next = '0;
        end else begin
            cnt_next = pending_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    // Scoreboard state and its count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
            pending_cnt <= '0;
        end else begin
            pending_reg <= pending_next;
            pending_cnt <= cnt_next;
        end
    end

    // Read ports: zero for x0, bypass from a same-cycle write, else storage.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              ra_zero;
            logic              wr_hit;
            logic [DATA_W-1:0] data;
            logic              busy;

            assign ra      = rd_addr[gi*ADDR_W +: ADDR_W];
            assign ra_zero = (ra == '0);
            assign wr_hit  = we && (wr_addr == ra);

            // Combinational read mux with bypass; busy hides a retiring write.
            always_comb begin
                data = '0;
                busy = 1'b0;
                if (!ra_zero) begin
                    data = wr_hit ? wr_data : mem[ra];
                    busy = pending_reg[ra] && !wr_hit;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data;
            assign rd_busy[gi]                  = busy;
        end
    endgenerate

endmodule
